// File: rtl/shift_pipe_pkg.sv
// rtl/shift_pipe_pkg.sv - op codes, widths and stage record shared by the shift pipe
package shift_pipe_pkg;

   localparam int SP_WIDTH   = 32;
   localparam int SP_TAG_W   = 5;
   localparam int SP_SHAMT_W = $clog2(SP_WIDTH);

   localparam logic [2:0] SHIFT_SLL = 3'b000;
   localparam logic [2:0] SHIFT_SRL = 3'b001;
   localparam logic [2:0] SHIFT_SRA = 3'b010;
   localparam logic [2:0] SHIFT_ROL = 3'b011;
   localparam logic [2:0] SHIFT_ROR = 3'b100;

   typedef struct packed {
      logic [SP_WIDTH-1:0]   data;
      logic [2:0]            op;
      logic [SP_SHAMT_W-1:0] shamt;
      logic [SP_TAG_W-1:0]   tag;
      logic                  err;
   } stage_rec_t;

   function automatic logic op_illegal(input logic [2:0] op);
      return op > SHIFT_ROR;
   endfunction

endpackage

// File: rtl/shift_pipe_if.sv
// rtl/shift_pipe_if.sv - issue/result handshake bundle between execute stage and shifter
interface shift_pipe_if
   import shift_pipe_pkg::*;
#(
   parameter int WIDTH = SP_WIDTH,
   parameter int TAG_W = SP_TAG_W
);
   localparam int SHAMT_W = $clog2(WIDTH);

   logic               in_valid;
   logic               in_ready;
   logic [2:0]         in_op;
   logic [WIDTH-1:0]   in_x;
   logic [SHAMT_W-1:0] in_shamt;
   logic [TAG_W-1:0]   in_tag;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_result;
   logic [TAG_W-1:0]   out_tag;
   logic               out_err;

   modport master (
      output in_valid, in_op, in_x, in_shamt, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag, out_err
   );

   modport slave (
      input  in_valid, in_op, in_x, in_shamt, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag, out_err
   );

endinterface

// File: rtl/shift_pipe_stage.sv
// rtl/shift_pipe_stage.sv - one shift level of the pipe plus its elastic stage register
module shift_pipe_stage
   import shift_pipe_pkg::*;
#(
   parameter int WIDTH = SP_WIDTH,
   parameter int SHIFT = 1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       flush_i,
   input  logic       adv_i,
   input  logic       up_valid_i,
   input  stage_rec_t up_rec_i,
   output logic       valid_o,
   output stage_rec_t rec_o
);

   localparam int BIT = $clog2(SHIFT);

   logic             valid_q;
   stage_rec_t       rec_q;
   stage_rec_t       rec_d;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] shifted;

   // An arithmetic shift never changes the msb, so the msb seen here is the original sign.
   always_comb begin
      x       = up_rec_i.data;
      shifted = x;
      case (up_rec_i.op)
         SHIFT_SLL: shifted = x << SHIFT;
         SHIFT_SRL: shifted = x >> SHIFT;
         SHIFT_SRA: shifted = $signed(x) >>> SHIFT;
         SHIFT_ROL: shifted = (x << SHIFT) | (x >> (WIDTH - SHIFT));
         SHIFT_ROR: shifted = (x >> SHIFT) | (x << (WIDTH - SHIFT));
         default:   shifted = x;
      endcase
      rec_d = up_rec_i;
      if (up_rec_i.shamt[BIT] && !up_rec_i.err) begin
         rec_d.data = shifted;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         rec_q   <= '0;
      end else begin
         if (flush_i) begin
            valid_q <= 1'b0;
         end else if (adv_i) begin
            valid_q <= up_valid_i;
         end
         if (adv_i && up_valid_i) begin
            rec_q <= rec_d;
         end
      end
   end

   assign valid_o = valid_q;
   assign rec_o   = rec_q;

endmodule

// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - pipelined barrel shifter, one register per shift level, largest shift first
module shift_pipe
   import shift_pipe_pkg::*;
#(
   parameter int WIDTH = SP_WIDTH
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        flush,
   shift_pipe_if.slave bus
);

   localparam int SHAMT_W = $clog2(WIDTH);

   // Index 0 is the issue port; index k+1 is the register of stage k.
   logic [SHAMT_W:0]   v;
   stage_rec_t         rec [SHAMT_W+1];
   logic [SHAMT_W-1:0] adv;
   logic               chain;
   stage_rec_t         in_rec;
   logic               unused_last;

   always_comb begin
      in_rec       = '0;
      in_rec.data  = bus.in_x;
      in_rec.op    = bus.in_op;
      in_rec.shamt = bus.in_shamt;
      in_rec.tag   = bus.in_tag;
      in_rec.err   = op_illegal(bus.in_op);
   end

   assign v[0]   = bus.in_valid;
   assign rec[0] = in_rec;

   // A stage may move when it is empty or everything downstream of it moves.
   always_comb begin
      chain            = !v[SHAMT_W] || bus.out_ready;
      adv[SHAMT_W-1]   = chain;
      for (int k = SHAMT_W - 2; k >= 0; k--) begin
         chain  = !v[k+1] || chain;
         adv[k] = chain;
      end
   end

   for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
      shift_pipe_stage #(
         .WIDTH (WIDTH),
         .SHIFT (1 << (SHAMT_W - 1 - k))
      ) u_stage (
         .clock      (clock),
         .reset_n    (reset_n),
         .flush_i    (flush),
         .adv_i      (adv[k]),
         .up_valid_i (v[k]),
         .up_rec_i   (rec[k]),
         .valid_o    (v[k+1]),
         .rec_o      (rec[k+1])
      );
   end

   assign bus.in_ready   = adv[0];
   assign bus.out_valid  = v[SHAMT_W];
   assign bus.out_result = rec[SHAMT_W].data;
   assign bus.out_tag    = rec[SHAMT_W].tag;
   assign bus.out_err    = rec[SHAMT_W].err;
   assign unused_last    = ^{rec[SHAMT_W].op, rec[SHAMT_W].shamt};

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Pipelined, parametrised barrel shifter for the execute stage. It implements logical left, logical right, arithmetic right, rotate-left and rotate-right on a WIDTH-bit operand. It has one register stage per shift level and a valid/ready handshake on both sides. A tag travels with each operation so the CPU writeback logic can match each result to its destination register. A flush input kills all in-flight work on a branch redirect.

## Interface
- WIDTH, 32: operand width; must be a power of two, minimum 8.
- TAG_W, 5: width of the opaque tag carried alongside each operation.
- SHAMT_W, log2(WIDTH): derived; not to be overridden.
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of every in-flight operation.
- in_valid  in  1  an operation is presented on the input.
- in_ready  out  1  the block accepts the input this cycle.
- in_op  in  3  operation code: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101–111 illegal.
- in_x  in  WIDTH  operand.
- in_shamt  in  SHAMT_W  shift amount.
- in_tag  in  TAG_W  tag returned unchanged with the result.
- out_valid  out  1  a result is presented on the output.
- out_ready  in  1  the consumer accepts the result this cycle.
- out_result  out  WIDTH  shifted value.
- out_tag  out  TAG_W  tag of the operation that produced the result.
- out_err  out  1  the operation used an illegal op code.

## Operation
- SHAMT_W stages, numbered k = 0 .. SHAMT_W-1.
- Stage k applies a shift of 2^(SHAMT_W-1-k) when the matching shamt bit is set. The largest shift is applied first, so stage 0 handles bit SHAMT_W-1 (16 when WIDTH=32).
- Each stage register holds: valid, data, op, remaining shamt bits, tag, err.
- Fill rule at each 2^n step:
  - SLL: low bits filled with 0.
  - SRL: high bits filled with 0.
  - SRA: high bits filled with the original bit WIDTH-1, which is carried unchanged through all stages.
  - ROL / ROR: vacated bits taken from the bits shifted out at the opposite end.
- shamt = 0 passes the operand through unchanged for every op.
- Illegal op: data passes through unshifted and err = 1. The operation still occupies a slot and still handshakes.
- Advance rule (elastic pipeline, no bubbles required):
  - adv[last] = !v[last] || out_ready.
  - adv[k] = !v[k] || adv[k+1].
  - in_ready = adv[0].
  - Stage k loads from its upstream stage when adv[k] is high. If the upstream stage is empty, the loaded valid is 0.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Inputs must be held stable while in_valid && !in_ready.
- Flush:
  - On the edge where flush = 1, every stage valid clears.
  - An input presented in the same cycle is dropped, even if in_ready = 1.
  - Data registers may keep stale values.
- out_result, out_tag and out_err are driven directly from the last stage register.
- Reset:
  - All valids clear; out_result, out_tag and out_err reset to 0.
  - in_ready is 1 after reset, because all stages are empty.
  - Reset asserted mid-operation discards all in-flight work, with no output.

## Timing
- Latency: accept at edge t gives out_valid at edge t + SHAMT_W (5 for WIDTH=32), provided out_ready is held high.
- Throughput: one operation per cycle under no backpressure.
- Capacity: SHAMT_W operations in flight. With out_ready low, the pipeline accepts until every stage is full, then in_ready drops in the same cycle the last stage would overflow.
- in_ready depends combinationally on out_ready through the advance chain. out_valid and the result outputs depend only on registers.
- out_ready rising with a full pipeline raises in_ready in the same cycle. A simultaneous accept and emit is legal and loses nothing.
- Ordering: results leave in acceptance order; no reordering, duplication or loss.

## Structure
- Shared package holds the op-code constants SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROL and SHIFT_ROR, plus the stage-record typedef (data, op, shamt, tag, err).
- One sub-module, shift_pipe_stage: parametrised by WIDTH and the stage shift distance. It contains the combinational shift/rotate of one level and its register with advance/flush control. The top instantiates it SHAMT_W times in a generate loop.

## Test plan
- Single ops, WIDTH=32, out_ready=1. Each result appears 5 cycles after accept:
  - SLL 0x00000001 by 31 gives 0x80000000.
  - SRL 0x80000000 by 31 gives 0x00000001.
  - SRA 0x80000000 by 31 gives 0xFFFFFFFF.
  - ROL 0x80000001 by 4 gives 0x00000018.
  - ROR 0x80000001 by 1 gives 0xC0000000.
- shamt = 0 and illegal op 3'b111 with operand 0x12345678: both give result 0x12345678; out_err is 0 for shamt = 0 and 1 for the illegal op.
- Eight back-to-back ops with tags 0–7 and out_ready=1: results appear on eight consecutive cycles starting at cycle 5, with tags in order 0–7.
- Backpressure with out_ready=0 and in_valid=1:
  - Exactly 5 operations are accepted, then in_ready=0.
  - Raising out_ready drains all 5 in order, and in_ready returns to 1 in the same cycle.
- Flush with 3 ops in flight and in_valid=1 in the flush cycle: no result ever emerges, out_valid is 0 from the next cycle, and a new op issued afterwards returns correctly after 5 cycles.
- reset_n pulsed low mid-stream:
  - All outputs go to 0 asynchronously, with out_valid=0.
  - After release in_ready=1, and no pre-reset result appears.
